// File: rtl/timer_cmp_pkg.sv
// Shared register map, control-bit indexes and channel control type for timer_cmp_bank.
// Optional periodic reload is enabled by defining TIMER_CMP_PERIODIC_EN.
package timer_cmp_pkg;

  localparam logic [31:0] CH_STRIDE  = 32'h20;
  localparam logic [31:0] OFF_CMP_LO = 32'h00;
  localparam logic [31:0] OFF_CMP_HI = 32'h04;
  localparam logic [31:0] OFF_CTRL   = 32'h08;
  localparam logic [31:0] OFF_STATUS = 32'h0C;
  localparam logic [31:0] OFF_PRD_LO = 32'h10;
  localparam logic [31:0] OFF_PRD_HI = 32'h14;

  localparam int CTRL_IE  = 0;
  localparam int CTRL_PER = 1;

  typedef struct packed {
    logic periodic;
    logic int_en;
  } chan_ctrl_t;

  function automatic logic [31:0] ctrl_word(input chan_ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_IE]  = c.int_en;
    w[CTRL_PER] = c.periodic;
    return w;
  endfunction

endpackage

// File: rtl/timer_cmp_chan.sv
// One compare channel: staged 64-bit compare value, sticky pend, optional periodic reload.
// The reload adder and period register exist only when TIMER_CMP_PERIODIC_EN is defined.
module timer_cmp_chan
  import timer_cmp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wdata,
  input  logic        we_cmp_lo,
  input  logic        we_cmp_hi,
  input  logic        we_ctrl,
  input  logic        we_status,
  input  logic        we_prd_lo,
  input  logic        we_prd_hi,
  input  logic [63:0] cnt,
  output logic [63:0] cmp,
  output chan_ctrl_t  ctrl,
  output logic        pend,
  output logic [63:0] period,
  output logic        irq
);

  logic [31:0] lo_shadow;
  logic        match;
  logic        reload;

  assign match = (cnt >= cmp);

`ifdef TIMER_CMP_PERIODIC_EN
  assign reload = ctrl.periodic && match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= '0;
    end else begin
      if (we_prd_lo) period[31:0]  <= wdata;
      if (we_prd_hi) period[63:32] <= wdata;
    end
  end
`else
  logic unused_prd;
  assign unused_prd = we_prd_lo | we_prd_hi;
  assign reload     = 1'b0;
  assign period     = '0;
`endif

  // A CMP_HI write always beats a same-cycle reload; set beats W1C on pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp       <= '1;
      lo_shadow <= '1;
      ctrl      <= '0;
      pend      <= 1'b0;
    end else begin
      if (we_cmp_lo) lo_shadow <= wdata;
      if (we_cmp_hi)   cmp <= {wdata, lo_shadow};
      else if (reload) cmp <= cmp + period;
      if (we_ctrl) begin
        ctrl.int_en <= wdata[CTRL_IE];
`ifdef TIMER_CMP_PERIODIC_EN
        ctrl.periodic <= wdata[CTRL_PER];
`endif
      end
      if (match)                      pend <= 1'b1;
      else if (we_status && wdata[0]) pend <= 1'b0;
    end
  end

  assign irq = pend & ctrl.int_en;

endmodule

// File: rtl/timer_cmp_bank.sv
// NUM_CH-channel compare bank: exact-word address decode, per-channel instances, read mux.
// wr_en is a single-cycle write strobe with no back-pressure; PRD registers need TIMER_CMP_PERIODIC_EN.
module timer_cmp_bank
  import timer_cmp_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic                  wr_en,
  input  logic [63:0]           cnt,
  output logic [31:0]           rdata,
  output logic [NUM_CH*64-1:0]  cmp,
  output logic [NUM_CH-1:0]     irq,
  output logic                  irq_any
);

  logic [63:0]       cmp_q    [NUM_CH];
  logic [63:0]       period_q [NUM_CH];
  chan_ctrl_t        ctrl_q   [NUM_CH];
  logic [NUM_CH-1:0] pend_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [31:0] CH_BASE = BASE_ADDR + CH_STRIDE * 32'(g);

    timer_cmp_chan u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .wdata     (wdata),
      .we_cmp_lo (wr_en && (addr == CH_BASE + OFF_CMP_LO)),
      .we_cmp_hi (wr_en && (addr == CH_BASE + OFF_CMP_HI)),
      .we_ctrl   (wr_en && (addr == CH_BASE + OFF_CTRL)),
      .we_status (wr_en && (addr == CH_BASE + OFF_STATUS)),
      .we_prd_lo (wr_en && (addr == CH_BASE + OFF_PRD_LO)),
      .we_prd_hi (wr_en && (addr == CH_BASE + OFF_PRD_HI)),
      .cnt       (cnt),
      .cmp       (cmp_q[g]),
      .ctrl      (ctrl_q[g]),
      .pend      (pend_q[g]),
      .period    (period_q[g]),
      .irq       (irq[g])
    );

    assign cmp[64*g +: 64] = cmp_q[g];
  end

`ifndef TIMER_CMP_PERIODIC_EN
  logic [NUM_CH-1:0] unused_period;
  for (genvar u = 0; u < NUM_CH; u++) begin : g_unused
    assign unused_period[u] = ^period_q[u];
  end
`endif

  // Unmapped and misaligned addresses fall through to zero.
  always_comb begin
    logic [31:0] ch_base;
    rdata   = '0;
    ch_base = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_base = BASE_ADDR + CH_STRIDE * 32'(i);
      if (addr == ch_base + OFF_CMP_LO) rdata = cmp_q[i][31:0];
      if (addr == ch_base + OFF_CMP_HI) rdata = cmp_q[i][63:32];
      if (addr == ch_base + OFF_CTRL)   rdata = ctrl_word(ctrl_q[i]);
      if (addr == ch_base + OFF_STATUS) rdata = {31'b0, pend_q[i]};
`ifdef TIMER_CMP_PERIODIC_EN
      if (addr == ch_base + OFF_PRD_LO) rdata = period_q[i][31:0];
      if (addr == ch_base + OFF_PRD_HI) rdata = period_q[i][63:32];
`endif
    end
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_cmp_bank.sv
// Bench for timer_cmp_bank: reset checks, table-driven vectors, hand sequences for
// periodic/wrap corners, and randomized traffic against a register-level reference model.
module tb_timer_cmp_bank;

  localparam int          NUM_CH = 4;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef TIMER_CMP_PERIODIC_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [31:0]          addr;
  logic [31:0]          wdata;
  logic                 wr_en;
  logic [63:0]          cnt;
  logic [31:0]          rdata;
  logic [NUM_CH*64-1:0] cmp;
  logic [NUM_CH-1:0]    irq;
  logic                 irq_any;

  timer_cmp_bank #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .wdata   (wdata),
    .wr_en   (wr_en),
    .cnt     (cnt),
    .rdata   (rdata),
    .cmp     (cmp),
    .irq     (irq),
    .irq_any (irq_any)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [63:0] m_cmp  [NUM_CH];
  logic [31:0] m_lo   [NUM_CH];
  logic        m_ie   [NUM_CH];
  logic        m_per  [NUM_CH];
  logic        m_pend [NUM_CH];
  logic [63:0] m_prd  [NUM_CH];

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cmp[i] = ALL1; m_lo[i] = 32'hFFFF_FFFF; m_ie[i] = 0;
      m_per[i] = 0; m_pend[i] = 0; m_prd[i] = '0;
    end
  endtask

  function automatic bit decode(input logic [31:0] a, output int ch, output int r);
    int off;
    ch = 0; r = 0;
    if (a < BASE || a >= BASE + 32'(NUM_CH * 32)) return 1'b0;
    off = int'(a - BASE);
    ch  = off / 32;
    r   = off % 32;
    return 1'b1;
  endfunction

  // Applies one clock edge worth of register rules using the pre-edge inputs.
  task automatic model_step();
    int ch, r;
    bit hit, w, match;
    hit = wr_en && decode(addr, ch, r);
    for (int i = 0; i < NUM_CH; i++) begin
      w     = hit && (ch == i);
      match = (cnt >= m_cmp[i]);
      if (w && r == 4)                   m_cmp[i] = {wdata, m_lo[i]};
      else if (PER_EN && m_per[i] && match) m_cmp[i] = m_cmp[i] + m_prd[i];
      if (w && r == 0) m_lo[i] = wdata;
      if (w && r == 8) begin
        m_ie[i]  = wdata[0];
        m_per[i] = PER_EN && wdata[1];
      end
      if (match) m_pend[i] = 1'b1;
      else if (w && r == 12 && wdata[0]) m_pend[i] = 1'b0;
      if (PER_EN && w && r == 16) m_prd[i][31:0]  = wdata;
      if (PER_EN && w && r == 20) m_prd[i][63:32] = wdata;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int ch, r;
    if (!decode(a, ch, r)) return 32'h0;
    case (r)
      0:  return m_cmp[ch][31:0];
      4:  return m_cmp[ch][63:32];
      8:  return {30'b0, m_per[ch], m_ie[ch]};
      12: return {31'b0, m_pend[ch]};
      16: return PER_EN ? m_prd[ch][31:0]  : 32'h0;
      20: return PER_EN ? m_prd[ch][63:32] : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [NUM_CH-1:0] m_irq();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_pend[i] & m_ie[i];
    return v;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we,
                     input logic [63:0] c);
    addr = a; wdata = d; wr_en = we; cnt = c;
    model_step();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(input logic [63:0] c);
    cyc(32'h0, 32'h0, 1'b0, c);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    cyc(a, 32'h0, 1'b0, cnt);
    chk(name, {32'h0, rdata}, {32'h0, exp});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("async_reset_cmp1", cmp[127:64], ALL1);
    chk("async_reset_irq", {60'h0, irq}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              wr_en;
    logic [63:0]       cnt;
    int                ch;
    logic [63:0]       exp_cmp;
    logic [NUM_CH-1:0] exp_irq;
  } vec_t;

  vec_t tbl[17];

  initial begin
    addr = '0; wdata = '0; wr_en = 1'b0; cnt = '0; rst_n = 1'b1;
    model_reset();
    #1;
    do_reset();

    // Reset state
    for (int i = 0; i < NUM_CH; i++) chk("reset_cmp", cmp[64*i +: 64], ALL1);
    chk("reset_irq", {60'h0, irq}, 64'h0);
    chk("reset_irq_any", {63'h0, irq_any}, 64'h0);
    rd("reset_ctrl", BASE + 32'h08, 32'h0);
    rd("reset_unmapped", BASE + 32'h200, 32'h0);

    // Atomic write (ch0), one-shot with W1C (ch1), masking (ch2), bad address
    tbl[0]  = '{32'h100, 32'h10,       1'b1, 64'h5_0000_0000, 0, ALL1,              4'b0000};
    tbl[1]  = '{32'h104, 32'h6,        1'b1, 64'h5_0000_0000, 0, 64'h6_0000_0010,   4'b0000};
    tbl[2]  = '{32'h120, 32'd100,      1'b1, 64'd0,           1, ALL1,              4'b0000};
    tbl[3]  = '{32'h124, 32'h0,        1'b1, 64'd0,           1, 64'd100,           4'b0000};
    tbl[4]  = '{32'h128, 32'h1,        1'b1, 64'd98,          1, 64'd100,           4'b0000};
    tbl[5]  = '{32'h0,   32'h0,        1'b0, 64'd99,          1, 64'd100,           4'b0000};
    tbl[6]  = '{32'h0,   32'h0,        1'b0, 64'd100,         1, 64'd100,           4'b0010};
    tbl[7]  = '{32'h12C, 32'h1,        1'b1, 64'd105,         1, 64'd100,           4'b0010};
    tbl[8]  = '{32'h120, 32'd200,      1'b1, 64'd105,         1, 64'd100,           4'b0010};
    tbl[9]  = '{32'h124, 32'h0,        1'b1, 64'd105,         1, 64'd200,           4'b0010};
    tbl[10] = '{32'h12C, 32'h1,        1'b1, 64'd105,         1, 64'd200,           4'b0000};
    tbl[11] = '{32'h140, 32'd10,       1'b1, 64'd105,         2, ALL1,              4'b0000};
    tbl[12] = '{32'h144, 32'h0,        1'b1, 64'd105,         2, 64'd10,            4'b0000};
    tbl[13] = '{32'h0,   32'h0,        1'b0, 64'd105,         2, 64'd10,            4'b0000};
    tbl[14] = '{32'h148, 32'h1,        1'b1, 64'd105,         2, 64'd10,            4'b0100};
    tbl[15] = '{32'h102, 32'hDEAD,     1'b1, 64'd105,         0, 64'h6_0000_0010,   4'b0100};
    tbl[16] = '{32'h104, 32'h6,        1'b1, 64'd105,         0, 64'h6_0000_0010,   4'b0100};

    for (int v = 0; v < 17; v++) begin
      cyc(tbl[v].addr, tbl[v].wdata, tbl[v].wr_en, tbl[v].cnt);
      chk($sformatf("vec%0d_cmp", v), cmp[64*tbl[v].ch +: 64], tbl[v].exp_cmp);
      chk($sformatf("vec%0d_irq", v), {60'h0, irq}, {60'h0, tbl[v].exp_irq});
      chk($sformatf("vec%0d_irq_any", v), {63'h0, irq_any}, {63'h0, |tbl[v].exp_irq});
    end

    rd("rd_ctrl1", 32'h128, 32'h1);
    rd("rd_status2", 32'h14C, 32'h1);
    rd("rd_status1", 32'h12C, 32'h0);
    rd("rd_status0", 32'h10C, 32'h0);
    rd("rd_cmp_hi0", 32'h104, 32'h6);
    rd("rd_cmp_lo0", 32'h100, 32'h10);
    rd("rd_cmp_lo3", 32'h160, 32'hFFFF_FFFF);
    rd("rd_unmapped", 32'h300, 32'h0);

    // Reset in the middle of activity
    do_reset();

`ifdef TIMER_CMP_PERIODIC_EN
    cyc(32'h170, 32'd25, 1'b1, 64'd0);
    cyc(32'h174, 32'h0,  1'b1, 64'd0);
    cyc(32'h160, 32'd50, 1'b1, 64'd0);
    cyc(32'h164, 32'h0,  1'b1, 64'd0);
    cyc(32'h168, 32'h3,  1'b1, 64'd0);
    rd("per_ctrl", 32'h168, 32'h3);
    rd("per_prd_lo", 32'h170, 32'd25);
    idle(64'd49);  chk("per_before", cmp[255:192], 64'd50);
    idle(64'd50);  chk("per_reload1", cmp[255:192], 64'd75);
    chk("per_irq", {60'h0, irq}, 64'h8);
    idle(64'd74);  chk("per_hold", cmp[255:192], 64'd75);
    idle(64'd75);  chk("per_reload2", cmp[255:192], 64'd100);
    cyc(32'h160, 32'd500, 1'b1, 64'd99);  chk("per_lo_staged", cmp[255:192], 64'd100);
    cyc(32'h164, 32'h0,   1'b1, 64'd100); chk("per_hi_override", cmp[255:192], 64'd500);
    cyc(32'h170, 32'h20,        1'b1, 64'd100);
    cyc(32'h160, 32'hFFFF_FFF0, 1'b1, 64'd100);
    cyc(32'h164, 32'hFFFF_FFFF, 1'b1, 64'd100);
    chk("wrap_setup", cmp[255:192], 64'hFFFF_FFFF_FFFF_FFF0);
    idle(64'hFFFF_FFFF_FFFF_FFF0);
    chk("wrap_reload", cmp[255:192], 64'h10);
`else
    cyc(32'h168, 32'h3, 1'b1, 64'd0);
    rd("noper_ctrl", 32'h168, 32'h1);
    cyc(32'h170, 32'h25, 1'b1, 64'd0);
    rd("noper_prd_lo", 32'h170, 32'h0);
    cyc(32'h160, 32'd50, 1'b1, 64'd0);
    cyc(32'h164, 32'h0,  1'b1, 64'd0);
    idle(64'd60); chk("oneshot_hold_a", cmp[255:192], 64'd50);
    idle(64'd61); chk("oneshot_hold_b", cmp[255:192], 64'd50);
    chk("oneshot_irq", {60'h0, irq}, 64'h8);
`endif

    // Randomized traffic against the model
    do_reset();
    begin
      logic [31:0] offs [8];
      logic [63:0] c;
      offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h02};
      c = 64'd0;
      for (int n = 0; n < 600; n++) begin
        int ch, k;
        logic [31:0] a, d, off;
        logic we;
        ch = $urandom_range(0, NUM_CH - 1);
        k  = $urandom_range(0, 9);
        off = (k < 8) ? offs[k] : 32'h18;
        a  = (k < 8) ? BASE + 32'(ch * 32) + off : 32'($urandom_range(0, 32'h400));
        we = ($urandom_range(0, 2) == 0);
        case (off)
          32'h00:  d = $urandom_range(0, 300);
          32'h04:  d = ($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0;
          32'h08:  d = $urandom_range(0, 3);
          32'h0C:  d = $urandom_range(0, 1);
          32'h10:  d = $urandom_range(0, 40);
          32'h14:  d = 32'h0;
          default: d = $urandom;
        endcase
        if ($urandom_range(0, 19) == 0) c = 64'($urandom_range(0, 150));
        else c = c + 64'($urandom_range(0, 3));
        cyc(a, d, we, c);
        for (int i = 0; i < NUM_CH; i++) chk("rnd_cmp", cmp[64*i +: 64], m_cmp[i]);
        chk("rnd_irq", {60'h0, irq}, {60'h0, m_irq()});
        chk("rnd_irq_any", {63'h0, irq_any}, {63'h0, |m_irq()});
        chk("rnd_rdata", {32'h0, rdata}, {32'h0, m_read(a)});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
